fp_mul_seq_param: RTL and testbench

- Parametrised sequential IEEE-754-style floating-point multiplier. Successor to the fixed FP32 shift-add multiplier.
- Format is generic: EXP_W exponent bits, MAN_W fraction bits.
- Additions over the FP32 block: correct bias subtraction, special-operand handling (zero/inf/NaN), overflow/underflow/invalid flags, optional round-to-nearest-even.
- Sits between operand registers and result writeback, driven by a start/done handshake.

---
 rtl/fp_mul_seq_param.sv | 176 +++++++++++++++++
 tb/tb_fp_mul_seq_param.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq_param.sv
// Sequential floating-point multiplier, generic {sign, EXP_W, MAN_W} format, radix-2 shift-add core.
// Latency: done pulses MAN_W+4 cycles after the accepting edge, fixed for every operand class.
// Backpressure: none; start is sampled only in IDLE and ignored while busy. Rounding: FP_MUL_SEQ_ROUND_EN.
module fp_mul_seq_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     busy,
    output logic                     done,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     invalid
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SW   = MAN_W + 1;
    localparam int PW   = 2 * SW;
    localparam int CW   = $clog2(MAN_W + 2);
    localparam int EW   = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_PACK} state_t;

    state_t            state, state_nxt;
    logic [W-1:0]      a_q, b_q;
    logic              sign_q;
    logic [EXP_W-1:0]  ea_q, eb_q;
    logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [PW-1:0]     mcand_q, prod_q;
    logic [SW-1:0]     mplier_q;
    logic [CW-1:0]     cnt_q;
    logic [MAN_W-1:0]  frac_q;
    logic              guard_q, sticky_q, exp_inc_q;

    // Field views of the latched operands.
    logic [EXP_W-1:0]  a_exp, b_exp;
    logic [MAN_W-1:0]  a_frac, b_frac;
    assign a_exp  = a_q[W-2 -: EXP_W];
    assign b_exp  = b_q[W-2 -: EXP_W];
    assign a_frac = a_q[MAN_W-1:0];
    assign b_frac = b_q[MAN_W-1:0];

    // Rounding increment; truncation build leaves guard/sticky unused.
    logic rnd_inc;
`ifdef FP_MUL_SEQ_ROUND_EN
    assign rnd_inc = guard_q & (sticky_q | frac_q[0]);
`else
    logic rnd_unused;
    assign rnd_unused = guard_q ^ sticky_q;
    assign rnd_inc    = 1'b0;
`endif

    logic [MAN_W:0]        frac_sum;
    logic signed [EW-1:0]  e_val;
    assign frac_sum = {1'b0, frac_q} + {{MAN_W{1'b0}}, rnd_inc};
    assign e_val    = EW'(ea_q) + EW'(eb_q) - EW'(BIAS) + EW'(exp_inc_q) + EW'(frac_sum[MAN_W]);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: fixed walk through the phases, MUL held for MAN_W+1 cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_UNPACK;
            S_UNPACK: state_nxt = S_MUL;
            S_MUL:    if (cnt_q == CW'(MAN_W)) state_nxt = S_NORM;
            S_NORM:   state_nxt = S_PACK;
            S_PACK:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Final selection of the packed result and flags, specials taking priority.
    logic [W-1:0] pack_res;
    logic         pack_ov, pack_un, pack_inv;
    always_comb begin
        pack_res = '0;
        pack_ov  = 1'b0;
        pack_un  = 1'b0;
        pack_inv = 1'b0;
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            pack_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            pack_inv = 1'b1;
        end else if (a_inf || b_inf) begin
            pack_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            pack_res = {sign_q, {(W-1){1'b0}}};
        end else if (e_val >= E_MAX) begin
            pack_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_ov  = 1'b1;
        end else if (e_val <= 0) begin
            pack_res = {sign_q, {(W-1){1'b0}}};
            pack_un  = 1'b1;
        end else begin
            pack_res = {sign_q, e_val[EXP_W-1:0], frac_sum[MAN_W-1:0]};
        end
    end

    // Datapath and output registers, advanced by the current phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0; b_q <= '0; sign_q <= 1'b0; ea_q <= '0; eb_q <= '0;
            a_zero <= 1'b0; a_inf <= 1'b0; a_nan <= 1'b0;
            b_zero <= 1'b0; b_inf <= 1'b0; b_nan <= 1'b0;
            mcand_q <= '0; prod_q <= '0; mplier_q <= '0; cnt_q <= '0;
            frac_q <= '0; guard_q <= 1'b0; sticky_q <= 1'b0; exp_inc_q <= 1'b0;
            busy <= 1'b0; done <= 1'b0; result <= '0;
            overflow <= 1'b0; underflow <= 1'b0; invalid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q  <= a;
                        b_q  <= b;
                        busy <= 1'b1;
                    end
                end
                S_UNPACK: begin
                    sign_q   <= a_q[W-1] ^ b_q[W-1];
                    ea_q     <= a_exp;
                    eb_q     <= b_exp;
                    // Subnormal inputs (exp==0) count as zero.
                    a_zero   <= (a_exp == '0);
                    b_zero   <= (b_exp == '0);
                    a_inf    <= (a_exp == '1) && (a_frac == '0);
                    b_inf    <= (b_exp == '1) && (b_frac == '0);
                    a_nan    <= (a_exp == '1) && (a_frac != '0);
                    b_nan    <= (b_exp == '1) && (b_frac != '0);
                    mcand_q  <= {{SW{1'b0}}, (a_exp == '0) ? {SW{1'b0}} : {1'b1, a_frac}};
                    mplier_q <= (b_exp == '0) ? {SW{1'b0}} : {1'b1, b_frac};
                    prod_q   <= '0;
                    cnt_q    <= '0;
                end
                S_MUL: begin
                    if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                end
                S_NORM: begin
                    if (prod_q[PW-1]) begin
                        frac_q    <= prod_q[PW-2 -: MAN_W];
                        guard_q   <= prod_q[PW-2-MAN_W];
                        sticky_q  <= |prod_q[PW-3-MAN_W:0];
                        exp_inc_q <= 1'b1;
                    end else begin
                        frac_q    <= prod_q[PW-3 -: MAN_W];
                        guard_q   <= prod_q[PW-3-MAN_W];
                        sticky_q  <= |prod_q[PW-4-MAN_W:0];
                        exp_inc_q <= 1'b0;
                    end
                end
                S_PACK: begin
                    result    <= pack_res;
                    overflow  <= pack_ov;
                    underflow <= pack_un;
                    invalid   <= pack_inv;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_seq_param.sv
// Directed bench for fp_mul_seq_param at FP32 defaults: vector table plus handshake corner sequences.
// Latency: expects done exactly 27 cycles after the accepting edge.
// Backpressure: exercises ignored mid-op start, back-to-back start and mid-op reset.
module tb_fp_mul_seq_param;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done, overflow, underflow, invalid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    fp_mul_seq_param #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        mid_pulse;
        logic [31:0] res;
        logic [2:0]  flags;   // {overflow, underflow, invalid}
    } vec_t;

    vec_t vecs[15];

    // Results of the last do_op call.
    int          op_lat;
    logic [31:0] op_res;
    logic [2:0]  op_flags;
    logic        op_busy_ok;
    logic        op_busy_at_done;
    logic        op_done_next;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One operation: start pulse, wait for done under a cycle bound.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic mid);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_lat = -1;
        op_busy_ok = busy;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done) begin
                op_lat = c;
                break;
            end
            if (!busy) op_busy_ok = 1'b0;
            if (mid) begin
                start = (c == 5);
                if (c == 5) begin a = 32'h4049_0FDB; b = 32'h4049_0FDB; end
            end
        end
        op_res = result;
        op_flags = {overflow, underflow, invalid};
        op_busy_at_done = busy;
        start = 1'b0;
        @(posedge clk); #1;
        op_done_next = done;
    endtask

    int done_cycles[$];
    int ndone;

    initial begin
        vecs[0]  = '{32'h3FC0_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 3'b000};
        vecs[1]  = '{32'hC040_0000, 32'h3F00_0000, 1'b1, 32'hBFC0_0000, 3'b000};
        vecs[2]  = '{32'h7F00_0000, 32'h4000_0000, 1'b0, 32'h7F80_0000, 3'b100};
        vecs[3]  = '{32'h0080_0000, 32'h3F00_0000, 1'b0, 32'h0000_0000, 3'b010};
        vecs[4]  = '{32'h7F80_0000, 32'h0000_0000, 1'b0, 32'h7FC0_0000, 3'b001};
        vecs[5]  = '{32'hFF80_0000, 32'h4000_0000, 1'b0, 32'hFF80_0000, 3'b000};
`ifdef FP_MUL_SEQ_ROUND_EN
        vecs[6]  = '{32'h3F80_0001, 32'h3FC0_0000, 1'b0, 32'h3FC0_0002, 3'b000};
`else
        vecs[6]  = '{32'h3F80_0001, 32'h3FC0_0000, 1'b0, 32'h3FC0_0001, 3'b000};
`endif
        vecs[7]  = '{32'h3FC0_0000, 32'h3FC0_0000, 1'b0, 32'h4010_0000, 3'b000};
        vecs[8]  = '{32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 3'b001};
        vecs[9]  = '{32'h8000_0000, 32'h4040_0000, 1'b0, 32'h8000_0000, 3'b000};
        vecs[10] = '{32'h0000_0001, 32'h4000_0000, 1'b0, 32'h0000_0000, 3'b000};
        vecs[11] = '{32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'hFF80_0000, 3'b000};
        vecs[12] = '{32'h7F00_0000, 32'h3F80_0000, 1'b0, 32'h7F00_0000, 3'b000};
        vecs[13] = '{32'h0080_0000, 32'h3F80_0000, 1'b0, 32'h0080_0000, 3'b000};
        vecs[14] = '{32'h0000_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 3'b001};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags", {29'd0, overflow, underflow, invalid}, 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].mid_pulse);
            check($sformatf("v%0d_latency", i), op_lat, 27);
            check($sformatf("v%0d_result", i), op_res, vecs[i].res);
            check($sformatf("v%0d_flags", i), {29'd0, op_flags}, {29'd0, vecs[i].flags});
            check($sformatf("v%0d_busy", i), {31'd0, op_busy_ok}, 32'd1);
            check($sformatf("v%0d_busy_at_done", i), {31'd0, op_busy_at_done}, 32'd0);
            check($sformatf("v%0d_done_one_cycle", i), {31'd0, op_done_next}, 32'd0);
        end

        // Mid-op start was ignored: no further operation starts, result holds.
        repeat (3) @(posedge clk); #1;
        check("idle_after_ops_busy", {31'd0, busy}, 32'd0);
        check("result_holds", result, vecs[14].res);

        // Back-to-back with start held high: done spacing is 28 cycles.
        @(negedge clk);
        a = 32'h3FC0_0000; b = 32'h4000_0000; start = 1'b1;
        ndone = 0;
        for (int c = 0; c < 100 && ndone < 2; c++) begin
            @(posedge clk); #1;
            if (done) begin
                done_cycles.push_back(c);
                ndone++;
                check($sformatf("b2b_result%0d", ndone), result, 32'h4040_0000);
            end
        end
        start = 1'b0;
        check("b2b_done_count", ndone, 2);
        if (ndone == 2) check("b2b_spacing", done_cycles[1] - done_cycles[0], 28);
        repeat (3) @(posedge clk); #1;
        check("b2b_stopped", {31'd0, busy}, 32'd0);

        // Reset 10 cycles into an operation aborts it.
        @(negedge clk);
        a = 32'h3FC0_0000; b = 32'h4000_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        do_op(32'h3F80_0000, 32'h3F80_0000, 1'b0);
        check("after_abort_latency", op_lat, 27);
        check("after_abort_result", op_res, 32'h3F80_0000);
        check("after_abort_flags", {29'd0, op_flags}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
